// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_pkg
// Brief    : Shared widths, command record and FSM states for the DDS
//            parameter scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int TS_W = 48;
    localparam int PH_W = 14;

    typedef struct packed {
        logic [TS_W-1:0] start_time;
        logic [TS_W-1:0] freq;
        logic [PH_W-1:0] phase;
        logic            sync;
    } dds_cmd_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dds_param_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_param_scheduler_if
// Brief    : Valid/ready command stream feeding the DDS parameter scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface dds_param_scheduler_if #(
    parameter int TS_W = dds_pkg::TS_W,
    parameter int PH_W = dds_pkg::PH_W
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [TS_W-1:0] cmd_time;
    logic [TS_W-1:0] cmd_freq;
    logic [PH_W-1:0] cmd_phase;
    logic            cmd_sync;

    modport master (
        output cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_sync,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_sync,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/dds_param_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dds_param_scheduler
// Brief    : Holds one timed DDS command and loads freq/phase/timeoffset into
//            the phase MAC registers when the timestamp reaches its target.
// Revision : 1.0 - initial release
// ============================================================================
module dds_param_scheduler #(
    parameter int FIRE_LEAD = 0,
    parameter int TS_W      = dds_pkg::TS_W,
    parameter int PH_W      = dds_pkg::PH_W
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    input  wire logic [TS_W-1:0] i_counter,
    dds_param_scheduler_if.slave cmd,
    input  wire logic            i_flush,
    input  wire logic            i_err_clr,
    output logic [TS_W-1:0]      o_timeoffset,
    output logic [TS_W-1:0]      o_freq,
    output logic [PH_W-1:0]      o_phase,
    output logic                 o_update_pulse,
    output logic                 o_armed,
    output logic                 o_late_error,
    output logic [15:0]          o_apply_count
);
    import dds_pkg::*;

    localparam logic [TS_W-1:0] c_LEAD = TS_W'(FIRE_LEAD);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TS_W-1:0] r_target;
    logic [TS_W-1:0] r_time;
    logic [TS_W-1:0] r_freq_h;
    logic [PH_W-1:0] r_phase_h;
    logic            r_sync_h;

    logic [TS_W-1:0] w_new_target;
    logic            w_reached;
    logic            w_ready;
    logic            w_apply;
    logic            w_capture;
    logic            w_late;

    // Saturate so an early start time fires immediately instead of wrapping.
    assign w_new_target = (cmd.cmd_time > c_LEAD) ? (cmd.cmd_time - c_LEAD) : '0;
    assign w_reached    = (i_counter >= r_target);

    always_comb begin
        w_ready     = 1'b0;
        w_apply     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_ready = !i_flush;
            end
            ARMED: begin
                w_ready = w_reached && !i_flush;
                w_apply = w_reached && !i_flush;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
        w_capture = cmd.cmd_valid && w_ready && resetn;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else if (w_capture) begin
            w_state_nxt = ARMED;
        end else if (w_apply) begin
            w_state_nxt = IDLE;
        end
    end

    assign cmd.cmd_ready = w_ready && resetn;
    assign w_late        = w_capture && (i_counter > w_new_target);
    assign o_armed       = (r_state == ARMED);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held command payload needs no reset: it is only consumed while ARMED.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_target  <= w_new_target;
            r_time    <= cmd.cmd_time;
            r_freq_h  <= cmd.cmd_freq;
            r_phase_h <= cmd.cmd_phase;
            r_sync_h  <= cmd.cmd_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_timeoffset   <= '0;
            o_freq         <= '0;
            o_phase        <= '0;
            o_update_pulse <= 1'b0;
            o_late_error   <= 1'b0;
            o_apply_count  <= '0;
        end else begin
            o_update_pulse <= w_apply;
            if (w_apply) begin
                o_freq        <= r_freq_h;
                o_phase       <= r_phase_h;
                o_apply_count <= o_apply_count + 16'd1;
                if (r_sync_h) begin
                    o_timeoffset <= r_time;
                end
            end
            if (w_late) begin
                o_late_error <= 1'b1;
            end else if (i_err_clr) begin
                o_late_error <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_param_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_param_scheduler
// Brief    : Self-checking bench: directed table rows, corner sequences and a
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_param_scheduler;
    import dds_pkg::*;

    localparam int TW = 48;
    localparam int PW = 14;

    typedef struct {
        dds_cmd_t        cmd;
        int              acc;
        int              exp_pulse;
        bit              exp_late;
        logic [TW-1:0]   exp_toff;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [TW-1:0] counter;
    logic          flush;
    logic          err_clr;

    logic [TW-1:0] toff0, freq0, toff4, freq4;
    logic [PW-1:0] phase0, phase4;
    logic          pulse0, armed0, late0, pulse4, armed4, late4;
    logic [15:0]   cnt0, cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dds_param_scheduler_if #(.TS_W(TW), .PH_W(PW)) if0 ();
    dds_param_scheduler_if #(.TS_W(TW), .PH_W(PW)) if4 ();

    dds_param_scheduler #(.FIRE_LEAD(0), .TS_W(TW), .PH_W(PW)) dut0 (
        .clk(clk), .resetn(resetn), .i_counter(counter), .cmd(if0.slave),
        .i_flush(flush), .i_err_clr(err_clr),
        .o_timeoffset(toff0), .o_freq(freq0), .o_phase(phase0),
        .o_update_pulse(pulse0), .o_armed(armed0), .o_late_error(late0),
        .o_apply_count(cnt0)
    );

    dds_param_scheduler #(.FIRE_LEAD(4), .TS_W(TW), .PH_W(PW)) dut4 (
        .clk(clk), .resetn(resetn), .i_counter(counter), .cmd(if4.slave),
        .i_flush(1'b0), .i_err_clr(1'b0),
        .o_timeoffset(toff4), .o_freq(freq4), .o_phase(phase4),
        .o_update_pulse(pulse4), .o_armed(armed4), .o_late_error(late4),
        .o_apply_count(cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd0(input bit v, input dds_cmd_t c);
        if0.cmd_valid = v;
        if0.cmd_time  = c.start_time;
        if0.cmd_freq  = c.freq;
        if0.cmd_phase = c.phase;
        if0.cmd_sync  = c.sync;
    endtask

    task automatic set_cmd4(input bit v, input dds_cmd_t c);
        if4.cmd_valid = v;
        if4.cmd_time  = c.start_time;
        if4.cmd_freq  = c.freq;
        if4.cmd_phase = c.phase;
        if4.cmd_sync  = c.sync;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
        if0.cmd_valid = 1'b0;
        if4.cmd_valid = 1'b0;
        counter       = '0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [TW-1:0] tgt(input logic [TW-1:0] t, input int lead);
        longint unsigned tl;
        tl = longint'(t);
        return (tl > longint'(lead)) ? TW'(tl - longint'(lead)) : '0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vecs[6];
        dds_cmd_t      q[$];
        int            pul_c[$];
        logic [TW-1:0] pul_f[$];
        logic [TW-1:0] pul_t[$];
        int            exp_c[3];
        logic [TW-1:0] exp_f[3];
        int            b_acc;
        int            npulse;
        bit            m_held, m_s, m_pulse, m_late, fire, accept, exp_ready;
        logic [TW-1:0] m_t, m_f, m_toff, m_freq;
        logic [PW-1:0] m_p, m_phase;
        logic [15:0]   m_cnt;
        dds_cmd_t      c;

        set_cmd0(1'b0, '0);
        set_cmd4(1'b0, '0);
        resetn = 1'b0; flush = 1'b0; err_clr = 1'b0; counter = '0;

        vecs[0] = '{cmd: '{start_time: 48'd20, freq: 48'h1000, phase: 14'h3FF, sync: 1'b1},
                    acc: 5,  exp_pulse: 21, exp_late: 1'b0, exp_toff: 48'd20};
        vecs[1] = '{cmd: '{start_time: 48'd10, freq: 48'h2222, phase: 14'h011, sync: 1'b1},
                    acc: 30, exp_pulse: 32, exp_late: 1'b1, exp_toff: 48'd10};
        vecs[2] = '{cmd: '{start_time: 48'd30, freq: 48'h3333, phase: 14'h022, sync: 1'b0},
                    acc: 30, exp_pulse: 32, exp_late: 1'b0, exp_toff: 48'd0};
        vecs[3] = '{cmd: '{start_time: 48'd0,  freq: 48'h4444, phase: 14'h033, sync: 1'b1},
                    acc: 0,  exp_pulse: 2,  exp_late: 1'b0, exp_toff: 48'd0};
        vecs[4] = '{cmd: '{start_time: 48'd31, freq: 48'h5555, phase: 14'h044, sync: 1'b1},
                    acc: 30, exp_pulse: 32, exp_late: 1'b0, exp_toff: 48'd31};
        vecs[5] = '{cmd: '{start_time: 48'd29, freq: 48'h6666, phase: 14'h055, sync: 1'b0},
                    acc: 30, exp_pulse: 32, exp_late: 1'b1, exp_toff: 48'd0};

        // Reset state
        do_reset();
        chk("reset_toff", toff0, 0);
        chk("reset_armed", armed0, 0);
        chk("reset_cnt", cnt0, 0);

        // Single-command table: pulse timing, late flag and applied values
        for (int i = 0; i < 6; i++) begin
            int pulse_at;
            bit accepted;
            bit cap_now;
            logic late_seen;
            do_reset();
            pulse_at = -1; accepted = 1'b0; late_seen = 1'b0;
            for (int k = 0; k < 400 && pulse_at < 0; k++) begin
                counter = TW'(k);
                if (k >= vecs[i].acc && !accepted) set_cmd0(1'b1, vecs[i].cmd);
                else if0.cmd_valid = 1'b0;
                #1;
                cap_now = if0.cmd_valid && if0.cmd_ready;
                if (cap_now) accepted = 1'b1;
                tick();
                if (cap_now) late_seen = late0;
                if (pulse0) pulse_at = k + 1;
            end
            if0.cmd_valid = 1'b0;
            chk($sformatf("row%0d_pulse_cycle", i), 64'(pulse_at), 64'(vecs[i].exp_pulse));
            chk($sformatf("row%0d_late", i), late_seen, vecs[i].exp_late);
            chk($sformatf("row%0d_toff", i), toff0, vecs[i].exp_toff);
            chk($sformatf("row%0d_freq", i), freq0, vecs[i].cmd.freq);
            chk($sformatf("row%0d_phase", i), phase0, vecs[i].cmd.phase);
            chk($sformatf("row%0d_cnt", i), cnt0, 1);
            tick();
            chk($sformatf("row%0d_pulse_single", i), pulse0, 0);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk($sformatf("row%0d_errclr", i), late0, 0);
        end

        // Reset while ARMED: everything clears and the command never applies
        counter = 48'd50;
        set_cmd0(1'b1, '{start_time: 48'd100, freq: 48'h7777, phase: 14'h066, sync: 1'b1});
        tick();
        if0.cmd_valid = 1'b0;
        chk("rst_armed_before", armed0, 1);
        counter = 48'd51;
        resetn  = 1'b0;
        #1;
        chk("rst_ready_low", if0.cmd_ready, 0);
        tick();
        resetn = 1'b1;
        chk("rst_outs", {toff0, freq0, phase0, pulse0, armed0, late0, cnt0}, 0);
        npulse = 0;
        for (int k = 52; k <= 110; k++) begin
            counter = TW'(k);
            tick();
            if (pulse0) npulse++;
        end
        chk("rst_no_pulse", npulse, 0);
        chk("rst_armed_after", armed0, 0);

        // Back-to-back commands with sync=0 after a sync=1 establishes timeoffset
        do_reset();
        q = {};
        q.push_back('{start_time: 48'd5,  freq: 48'h11,   phase: 14'h001, sync: 1'b1});
        q.push_back('{start_time: 48'd40, freq: 48'hAAAA, phase: 14'h0AA, sync: 1'b0});
        q.push_back('{start_time: 48'd41, freq: 48'hBBBB, phase: 14'h0BB, sync: 1'b0});
        exp_c = '{6, 41, 42};
        exp_f = '{48'h11, 48'hAAAA, 48'hBBBB};
        b_acc = -1;
        for (int k = 1; k < 60; k++) begin
            bit fired;
            counter = TW'(k);
            if (q.size() > 0) set_cmd0(1'b1, q[0]);
            else if0.cmd_valid = 1'b0;
            #1;
            fired = if0.cmd_valid && if0.cmd_ready;
            tick();
            if (fired) begin
                if (q.size() == 1) b_acc = k;
                void'(q.pop_front());
            end
            if (pulse0) begin
                pul_c.push_back(k + 1);
                pul_f.push_back(freq0);
                pul_t.push_back(toff0);
            end
        end
        if0.cmd_valid = 1'b0;
        chk("b2b_npulse", pul_c.size(), 3);
        chk("b2b_second_accept", 64'(b_acc), 40);
        for (int k = 0; k < pul_c.size() && k < 3; k++) begin
            chk($sformatf("b2b_pulse%0d_cycle", k), pul_c[k], exp_c[k]);
            chk($sformatf("b2b_pulse%0d_freq", k), pul_f[k], exp_f[k]);
            chk($sformatf("b2b_pulse%0d_toff", k), pul_t[k], 5);
        end
        chk("b2b_cnt", cnt0, 3);

        // Flush drops the armed command; outputs hold
        counter = 48'd100;
        set_cmd0(1'b1, '{start_time: 48'd200, freq: 48'hCCCC, phase: 14'h0CC, sync: 1'b1});
        tick();
        if0.cmd_valid = 1'b0;
        chk("flush_armed_before", armed0, 1);
        for (int k = 101; k < 150; k++) begin
            counter = TW'(k);
            tick();
        end
        counter = 48'd150;
        flush   = 1'b1;
        set_cmd0(1'b1, '{start_time: 48'd160, freq: 48'hDDDD, phase: 14'h0DD, sync: 1'b1});
        #1;
        chk("flush_ready_low", if0.cmd_ready, 0);
        tick();
        flush = 1'b0;
        if0.cmd_valid = 1'b0;
        chk("flush_armed_after", armed0, 0);
        npulse = 0;
        for (int k = 151; k <= 210; k++) begin
            counter = TW'(k);
            tick();
            if (pulse0) npulse++;
        end
        chk("flush_no_pulse", npulse, 0);
        chk("flush_hold_freq", freq0, 48'hBBBB);
        chk("flush_hold_phase", phase0, 14'h0BB);
        chk("flush_hold_toff", toff0, 5);
        chk("flush_hold_cnt", cnt0, 3);

        // FIRE_LEAD=4: saturating target, boundary and late detection
        do_reset();
        set_cmd4(1'b1, '{start_time: 48'd2, freq: 48'h55, phase: 14'h007, sync: 1'b1});
        #1;
        chk("lead_ready", if4.cmd_ready, 1);
        tick();
        if4.cmd_valid = 1'b0;
        chk("lead_sat_late", late4, 0);
        chk("lead_sat_armed", armed4, 1);
        counter = 48'd1;
        tick();
        chk("lead_sat_pulse", pulse4, 1);
        chk("lead_sat_toff", toff4, 2);
        chk("lead_sat_freq", freq4, 48'h55);
        chk("lead_sat_cnt", cnt4, 1);
        counter = 48'd6;
        set_cmd4(1'b1, '{start_time: 48'd10, freq: 48'h66, phase: 14'h008, sync: 1'b0});
        tick();
        if4.cmd_valid = 1'b0;
        chk("lead_eq_late", late4, 0);
        counter = 48'd7;
        tick();
        chk("lead_eq_pulse", pulse4, 1);
        chk("lead_eq_freq", freq4, 48'h66);
        counter = 48'd9;
        set_cmd4(1'b1, '{start_time: 48'd10, freq: 48'h77, phase: 14'h009, sync: 1'b0});
        tick();
        if4.cmd_valid = 1'b0;
        chk("lead_gt_late", late4, 1);

        // Randomized run against the reference model
        do_reset();
        m_held = 0; m_s = 0; m_pulse = 0; m_late = 0;
        m_t = '0; m_f = '0; m_p = '0; m_toff = '0; m_freq = '0; m_phase = '0; m_cnt = '0;
        for (int n = 0; n < 3000; n++) begin
            int off;
            counter = counter + TW'($urandom_range(0, 3));
            resetn  = ($urandom_range(0, 199) != 0);
            flush   = ($urandom_range(0, 29) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            off = $urandom_range(0, 25);
            c.start_time = (counter + TW'(off) >= 5) ? counter + TW'(off) - 5 : '0;
            c.freq  = TW'({$urandom, $urandom});
            c.phase = PW'($urandom);
            c.sync  = $urandom_range(0, 1) != 0;
            set_cmd0($urandom_range(0, 1) != 0, c);
            #1;
            exp_ready = resetn && !flush && (!m_held || counter >= tgt(m_t, 0));
            chk("rnd_ready", if0.cmd_ready, exp_ready);
            accept = if0.cmd_valid && exp_ready;
            if (!resetn) begin
                m_held = 0; m_pulse = 0; m_late = 0;
                m_toff = '0; m_freq = '0; m_phase = '0; m_cnt = '0;
            end else begin
                fire    = m_held && !flush && counter >= tgt(m_t, 0);
                m_pulse = fire;
                if (fire) begin
                    m_freq  = m_f;
                    m_phase = m_p;
                    if (m_s) m_toff = m_t;
                    m_cnt++;
                end
                if (accept && counter > tgt(c.start_time, 0)) m_late = 1;
                else if (err_clr) m_late = 0;
                if (flush) m_held = 0;
                else if (accept) begin
                    m_held = 1; m_t = c.start_time; m_f = c.freq; m_p = c.phase; m_s = c.sync;
                end else if (fire) m_held = 0;
            end
            tick();
            chk("rnd_toff", toff0, m_toff);
            chk("rnd_freq", freq0, m_freq);
            chk("rnd_phase", phase0, m_phase);
            chk("rnd_pulse", pulse0, m_pulse);
            chk("rnd_armed", armed0, m_held);
            chk("rnd_late", late0, m_late);
            chk("rnd_cnt", cnt0, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
